fetch_decode: RTL

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch and decode front end: fetches words from instruction memory,
// collects optional prefix/constant words and issues one decoded main word at a time.
module fetch_decode #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    output logic              halted,
    output logic [2:0]        op,
    output logic              form,
    output logic [1:0]        vec,
    output logic [3:0]        A,
    output logic [3:0]        B,
    output logic [3:0]        C,
    output logic [3:0]        D,
    output logic [3:0]        Y1,
    output logic [3:0]        Y2,
    output logic [3:0]        zero_reg,
    output logic [1:0]        write,
    output logic              const_a,
    output logic              program_counter_inc,
    output logic [31:0]       constant,
    output logic              copy_neg,
    output logic [3:0]        copy_select
);

    typedef enum logic [1:0] {S_FETCH, S_FETCH_CONST, S_ISSUE, S_HALT} state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        op_q, op_d;
    logic              form_q, form_d;
    logic [1:0]        vec_q, vec_d;
    logic [3:0]        src_a_q, src_a_d, src_b_q, src_b_d, src_c_q, src_c_d, src_d_q, src_d_d;
    logic [3:0]        y1_q, y1_d, y2_q, y2_d;
    logic [3:0]        zero_q, zero_d;
    logic [1:0]        wr_q, wr_d;
    logic              const_a_q, const_a_d;
    logic              copy_neg_q, copy_neg_d;
    logic [3:0]        copy_sel_q, copy_sel_d;
    logic [31:0]       constant_q, constant_d;
    logic              halted_q, halted_d;

    logic fetch_active;
    logic accept;
    logic issue_go;

    // run_q keeps the request low until the first clock edge after reset release.
    assign fetch_active = run_q && (state_q == S_FETCH || state_q == S_FETCH_CONST);
    assign accept       = fetch_active && imem_ack;
    assign issue_go     = (state_q == S_ISSUE) && !stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        form_d     = form_q;
        vec_d      = vec_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        src_c_d    = src_c_q;
        src_d_d    = src_d_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        zero_d     = zero_q;
        wr_d       = wr_q;
        const_a_d  = const_a_q;
        copy_neg_d = copy_neg_q;
        copy_sel_d = copy_sel_q;
        constant_d = constant_q;
        halted_d   = halted_q;
        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    if (imem_rdata[1:0] != 2'b00) begin
                        op_d    = imem_rdata[31:29];
                        form_d  = imem_rdata[28];
                        vec_d   = imem_rdata[27:26];
                        src_a_d = imem_rdata[25:22];
                        src_b_d = imem_rdata[21:18];
                        src_c_d = imem_rdata[17:14];
                        src_d_d = imem_rdata[13:10];
                        y1_d    = imem_rdata[9:6];
                        y2_d    = imem_rdata[5:2];
                        wr_d    = imem_rdata[1:0];
                        zero_d  = {imem_rdata[13:10] == 4'd0, imem_rdata[17:14] == 4'd0,
                                   imem_rdata[21:18] == 4'd0,
                                   (imem_rdata[25:22] == 4'd0) && !const_a_q};
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_ISSUE;
                    end else if (imem_rdata[25]) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        const_a_d  = imem_rdata[31];
                        copy_neg_d = imem_rdata[30];
                        copy_sel_d = imem_rdata[29:26];
                        pc_d       = pc_q + ADDR_W'(1);
                        state_d    = imem_rdata[31] ? S_FETCH_CONST : S_FETCH;
                    end
                end
            end
            S_FETCH_CONST: begin
                if (accept) begin
                    constant_d = imem_rdata;
                    pc_d       = pc_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (issue_go) begin
                    const_a_d  = 1'b0;
                    copy_neg_d = 1'b0;
                    copy_sel_d = 4'd0;
                    state_d    = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            run_q      <= 1'b0;
            pc_q       <= RESET_PC;
            op_q       <= '0;
            form_q     <= 1'b0;
            vec_q      <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            src_c_q    <= '0;
            src_d_q    <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            zero_q     <= '0;
            wr_q       <= '0;
            const_a_q  <= 1'b0;
            copy_neg_q <= 1'b0;
            copy_sel_q <= '0;
            constant_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            pc_q       <= pc_d;
            op_q       <= op_d;
            form_q     <= form_d;
            vec_q      <= vec_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            src_c_q    <= src_c_d;
            src_d_q    <= src_d_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            zero_q     <= zero_d;
            wr_q       <= wr_d;
            const_a_q  <= const_a_d;
            copy_neg_q <= copy_neg_d;
            copy_sel_q <= copy_sel_d;
            constant_q <= constant_d;
            halted_q   <= halted_d;
        end
    end

    // Write enables and the PC pulse exist only in the cycle the datapath accepts the issue.
    assign write               = issue_go ? wr_q : 2'b00;
    assign program_counter_inc = issue_go;
    assign imem_req            = fetch_active;
    assign imem_addr           = pc_q;
    assign halted              = halted_q;
    assign op                  = op_q;
    assign form                = form_q;
    assign vec                 = vec_q;
    assign A                   = src_a_q;
    assign B                   = src_b_q;
    assign C                   = src_c_q;
    assign D                   = src_d_q;
    assign Y1                  = y1_q;
    assign Y2                  = y2_q;
    assign zero_reg            = zero_q;
    assign const_a             = const_a_q;
    assign constant            = constant_q;
    assign copy_neg            = copy_neg_q;
    assign copy_select         = copy_sel_q;

endmodule
